// File: rtl/alu_cmp_pkg.sv
// Shared constants for the pipelined comparator: compare modes, default widths
// and the flag ordering used when results are packed for checking.
package alu_cmp_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    typedef enum logic [2:0] {
        EQU = 3'd0,
        NEQ = 3'd1,
        LTH = 3'd2,
        LTE = 3'd3,
        GTH = 3'd4,
        GTE = 3'd5
    } flag_idx_e;

endpackage

// File: rtl/alu_cmp_pipe_cmp_slice.sv
// Unsigned equal / less-than for one N-bit slice of the operands.
module cmp_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/alu_cmp_pipe.sv
// Two-stage signed/unsigned comparator: stage 1 compares hi/lo halves,
// stage 2 merges them into flags and selects min/max.
module alu_cmp_pipe
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_vld,
    output logic             src_rdy,
    input  logic             src_mode,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [TAG_W-1:0] src_tag,
    output logic             dst_vld,
    input  logic             dst_rdy,
    output logic             dst_equ,
    output logic             dst_neq,
    output logic             dst_lth,
    output logic             dst_lte,
    output logic             dst_gth,
    output logic             dst_gte,
    output logic [WIDTH-1:0] dst_min,
    output logic [WIDTH-1:0] dst_max,
    output logic [TAG_W-1:0] dst_tag
);

    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    // Handshake: a transfer happens on a cycle where vld & rdy are both 1 at the
    // rising edge. The whole pipe advances together on en; a held output stalls
    // both stages and deasserts src_rdy (no bubble collapsing).
    logic en;

    logic [HI-1:0] hi_a, hi_b;
    logic          eq_hi, lt_hi, eq_lo, lt_lo;

    logic             s1_vld_d, s1_vld_q;
    logic             s1_eq_hi_d, s1_eq_hi_q, s1_lt_hi_d, s1_lt_hi_q;
    logic             s1_eq_lo_d, s1_eq_lo_q, s1_lt_lo_d, s1_lt_lo_q;
    logic [WIDTH-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

    logic             equ_c, lth_c;
    logic             dst_vld_d, dst_vld_q;
    logic             equ_d, equ_q, neq_d, neq_q, lth_d, lth_q;
    logic             lte_d, lte_q, gth_d, gth_q, gte_d, gte_q;
    logic [WIDTH-1:0] min_d, min_q, max_d, max_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign hi_a = {src0[WIDTH-1] ^ (src_mode == CMP_SIGNED), src0[WIDTH-2:LO]};
    assign hi_b = {src1[WIDTH-1] ^ (src_mode == CMP_SIGNED), src1[WIDTH-2:LO]};

    cmp_slice #(.N(HI)) u_cmp_hi (
        .a  (hi_a),
        .b  (hi_b),
        .eq (eq_hi),
        .lt (lt_hi)
    );

    cmp_slice #(.N(LO)) u_cmp_lo (
        .a  (src0[LO-1:0]),
        .b  (src1[LO-1:0]),
        .eq (eq_lo),
        .lt (lt_lo)
    );

    always_comb begin
        en         = ~dst_vld_q | dst_rdy;
        s1_vld_d   = s1_vld_q;
        s1_eq_hi_d = s1_eq_hi_q;
        s1_lt_hi_d = s1_lt_hi_q;
        s1_eq_lo_d = s1_eq_lo_q;
        s1_lt_lo_d = s1_lt_lo_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (en) begin
            s1_vld_d = src_vld;
            if (src_vld) begin
                s1_eq_hi_d = eq_hi;
                s1_lt_hi_d = lt_hi;
                s1_eq_lo_d = eq_lo;
                s1_lt_lo_d = lt_lo;
                s1_a_d     = src0;
                s1_b_d     = src1;
                s1_tag_d   = src_tag;
            end
        end
    end

    // Result registers only load on a valid op so they keep the last result
    // while the output is idle.
    always_comb begin
        equ_c     = s1_eq_hi_q & s1_eq_lo_q;
        lth_c     = s1_lt_hi_q | (s1_eq_hi_q & s1_lt_lo_q);
        dst_vld_d = dst_vld_q;
        equ_d     = equ_q;
        neq_d     = neq_q;
        lth_d     = lth_q;
        lte_d     = lte_q;
        gth_d     = gth_q;
        gte_d     = gte_q;
        min_d     = min_q;
        max_d     = max_q;
        tag_d     = tag_q;
        if (en) begin
            dst_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                equ_d = equ_c;
                neq_d = ~equ_c;
                lth_d = lth_c;
                lte_d = lth_c | equ_c;
                gth_d = ~(lth_c | equ_c);
                gte_d = ~lth_c;
                min_d = lth_c ? s1_a_q : s1_b_q;
                max_d = lth_c ? s1_b_q : s1_a_q;
                tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_eq_hi_q <= 1'b0;
            s1_lt_hi_q <= 1'b0;
            s1_eq_lo_q <= 1'b0;
            s1_lt_lo_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            dst_vld_q  <= 1'b0;
            equ_q      <= 1'b0;
            neq_q      <= 1'b0;
            lth_q      <= 1'b0;
            lte_q      <= 1'b0;
            gth_q      <= 1'b0;
            gte_q      <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            tag_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_eq_hi_q <= s1_eq_hi_d;
            s1_lt_hi_q <= s1_lt_hi_d;
            s1_eq_lo_q <= s1_eq_lo_d;
            s1_lt_lo_q <= s1_lt_lo_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            dst_vld_q  <= dst_vld_d;
            equ_q      <= equ_d;
            neq_q      <= neq_d;
            lth_q      <= lth_d;
            lte_q      <= lte_d;
            gth_q      <= gth_d;
            gte_q      <= gte_d;
            min_q      <= min_d;
            max_q      <= max_d;
            tag_q      <= tag_d;
        end
    end

    assign src_rdy = en;
    assign dst_vld = dst_vld_q;
    assign dst_equ = equ_q;
    assign dst_neq = neq_q;
    assign dst_lth = lth_q;
    assign dst_lte = lte_q;
    assign dst_gth = gth_q;
    assign dst_gte = gte_q;
    assign dst_min = min_q;
    assign dst_max = max_q;
    assign dst_tag = tag_q;

endmodule
